// File: rtl/adc_capture.sv
// rtl/adc_capture.sv - AD9643 capture stage: rdy settle FSM, two's-complement conversion, FWFT output buffer
// Optional ramp-pattern checker and pat_err_cnt port: define ADC_CAPTURE_PATTERN_CHK_EN.
module adc_capture #(
    parameter int DATA_WIDTH    = 14,
    parameter int SETTLE_CYCLES = 64,
    parameter int FIFO_DEPTH    = 4,
    parameter int TWOS_COMP     = 1
) (
    input  logic                  clk_adc,
    input  logic                  rst_adc_n,
    input  logic [DATA_WIDTH-1:0] adc_dat_in,
    input  logic                  adc_or_in,
    input  logic                  idelay_rdy,
    input  logic                  capture_en,
    input  logic                  clr_stat,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tuser,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [1:0]            state,
    output logic                  overflow,
    output logic [15:0]           or_count
`ifdef ADC_CAPTURE_PATTERN_CHK_EN
    ,
    output logic [15:0]           pat_err_cnt
`endif
);
    localparam int              AW          = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     FULL_CNT    = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0]     SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_RDY = 2'd0,
        SETTLE   = 2'd1,
        RUN      = 2'd2
    } state_t;

    state_t                state_q;
    logic [1:0]            rdy_sync;
    logic                  rdy;
    logic [15:0]           settle_cnt;
    logic [DATA_WIDTH-1:0] s1_dat;
    logic                  s1_or;
    logic [DATA_WIDTH-1:0] s2_dat;
    logic                  s2_or;
    logic [DATA_WIDTH-1:0] mem_dat [FIFO_DEPTH];
    logic                  mem_or  [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  push_req;
    logic                  flush;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic                  drop_q;
    logic                  or_ev_q;

    assign rdy      = rdy_sync[1];
    assign state    = state_q;
    assign m_tvalid = (count != '0);
    assign m_tdata  = mem_dat[rd_ptr];
    assign m_tuser  = mem_or[rd_ptr];

    assign push_req = (state_q == RUN) && rdy && capture_en;
    assign flush    = (state_q == RUN) && !rdy;
    assign full     = (count == FULL_CNT);
    assign pop      = m_tvalid && m_tready;
    // A full buffer still accepts a sample when the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

`ifdef ADC_CAPTURE_PATTERN_CHK_EN
    logic [DATA_WIDTH-1:0] s2_raw;
    logic [DATA_WIDTH-1:0] pat_ref;
    logic [DATA_WIDTH-1:0] pat_next;
    logic                  pat_ref_vld;

    assign s2_raw   = (TWOS_COMP != 0) ? {~s2_dat[DATA_WIDTH-1], s2_dat[DATA_WIDTH-2:0]} : s2_dat;
    assign pat_next = pat_ref + DATA_WIDTH'(1);
`endif

    always_ff @(posedge clk_adc) begin
        if (!rst_adc_n) begin
            state_q    <= WAIT_RDY;
            rdy_sync   <= '0;
            settle_cnt <= '0;
            s1_dat     <= '0;
            s1_or      <= 1'b0;
            s2_dat     <= '0;
            s2_or      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_q     <= 1'b0;
            or_ev_q    <= 1'b0;
            overflow   <= 1'b0;
            or_count   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_dat[i] <= '0;
                mem_or[i]  <= 1'b0;
            end
`ifdef ADC_CAPTURE_PATTERN_CHK_EN
            pat_ref     <= '0;
            pat_ref_vld <= 1'b0;
            pat_err_cnt <= '0;
`endif
        end else begin
            rdy_sync <= {rdy_sync[0], idelay_rdy};
            s1_dat   <= adc_dat_in;
            s1_or    <= adc_or_in;
            s2_dat   <= (TWOS_COMP != 0) ? {~s1_dat[DATA_WIDTH-1], s1_dat[DATA_WIDTH-2:0]} : s1_dat;
            s2_or    <= s1_or;
            drop_q   <= drop;
            or_ev_q  <= push_req && s2_or;

            case (state_q)
                WAIT_RDY: begin
                    if (rdy) begin
                        state_q    <= SETTLE;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    if (!rdy)
                        state_q <= WAIT_RDY;
                    else if (settle_cnt == SETTLE_LAST)
                        state_q <= RUN;
                    else
                        settle_cnt <= settle_cnt + 16'd1;
                end
                RUN: begin
                    if (!rdy)
                        state_q <= WAIT_RDY;
                end
                default: state_q <= WAIT_RDY;
            endcase

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem_dat[wr_ptr] <= s2_dat;
                    mem_or[wr_ptr]  <= s2_or;
                    wr_ptr          <= wr_ptr + 1'b1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)
                    count <= count + 1'b1;
                else if (!push && pop)
                    count <= count - 1'b1;
            end

            if (clr_stat) begin
                overflow <= 1'b0;
                or_count <= '0;
            end else begin
                if (drop_q)
                    overflow <= 1'b1;
                if (or_ev_q && (or_count != 16'hFFFF))
                    or_count <= or_count + 16'd1;
            end

`ifdef ADC_CAPTURE_PATTERN_CHK_EN
            // The first push of each RUN visit only seeds the ramp reference.
            if (state_q != RUN) begin
                pat_ref_vld <= 1'b0;
            end else if (push_req) begin
                pat_ref     <= s2_raw;
                pat_ref_vld <= 1'b1;
            end
            if (clr_stat)
                pat_err_cnt <= '0;
            else if (push_req && pat_ref_vld && (s2_raw != pat_next) && (pat_err_cnt != 16'hFFFF))
                pat_err_cnt <= pat_err_cnt + 16'd1;
`endif
        end
    end
endmodule

// File: tb/tb_adc_capture.sv
// tb/tb_adc_capture.sv - directed-vector bench for adc_capture (SETTLE_CYCLES = 8, FIFO_DEPTH = 4)
module tb_adc_capture;
    logic        clk_adc = 1'b0;
    logic        rst_adc_n;
    logic [13:0] adc_dat_in;
    logic        adc_or_in;
    logic        idelay_rdy;
    logic        capture_en;
    logic        clr_stat;
    logic [13:0] m_tdata;
    logic        m_tuser;
    logic        m_tvalid;
    logic        m_tready;
    logic [1:0]  state;
    logic        overflow;
    logic [15:0] or_count;
`ifdef ADC_CAPTURE_PATTERN_CHK_EN
    logic [15:0] pat_err_cnt;
`endif

    int vectors    = 0;
    int miscompares = 0;

    adc_capture #(
        .DATA_WIDTH    (14),
        .SETTLE_CYCLES (8),
        .FIFO_DEPTH    (4),
        .TWOS_COMP     (1)
    ) dut (
        .clk_adc    (clk_adc),
        .rst_adc_n  (rst_adc_n),
        .adc_dat_in (adc_dat_in),
        .adc_or_in  (adc_or_in),
        .idelay_rdy (idelay_rdy),
        .capture_en (capture_en),
        .clr_stat   (clr_stat),
        .m_tdata    (m_tdata),
        .m_tuser    (m_tuser),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .state      (state),
        .overflow   (overflow),
        .or_count   (or_count)
`ifdef ADC_CAPTURE_PATTERN_CHK_EN
        ,
        .pat_err_cnt(pat_err_cnt)
`endif
    );

    always #5 clk_adc = ~clk_adc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_adc);
        #1;
    endtask

    task automatic feed(input logic [13:0] d, input logic o, input logic en);
        adc_dat_in = d;
        adc_or_in  = o;
        capture_en = en;
        tick();
    endtask

    logic [31:0] drain_exp [4];
    logic        or_pat [5];

    initial begin
        rst_adc_n  = 1'b0;
        adc_dat_in = '0;
        adc_or_in  = 1'b0;
        idelay_rdy = 1'b0;
        capture_en = 1'b1;
        clr_stat   = 1'b0;
        m_tready   = 1'b0;
        tick();
        tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_tvalid", 32'(m_tvalid), 0);
        chk("rst_tdata", 32'(m_tdata), 0);
        chk("rst_tuser", 32'(m_tuser), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_or_count", 32'(or_count), 0);
        rst_adc_n = 1'b1;
        tick();
        tick();
        chk("idle_state", 32'(state), 0);

        // settle sequence; idelay_rdy first sampled at step 1
        idelay_rdy = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 2)  chk("settle_s2", 32'(state), 0);
            if (i == 3)  chk("settle_s3", 32'(state), 1);
            if (i == 10) chk("settle_s10", 32'(state), 1);
            if (i == 11) begin
                chk("settle_s11", 32'(state), 2);
                chk("settle_nopush", 32'(m_tvalid), 0);
            end
            if (i == 12) chk("first_push_11", 32'(m_tvalid), 1);
        end
        capture_en = 1'b0;
        m_tready   = 1'b1;
        tick();
        tick();
        chk("settle_drained", 32'(m_tvalid), 0);

        // conversion and latency
        feed(14'h0000, 1'b0, 1'b0);
        feed(14'h2000, 1'b0, 1'b0);
        feed(14'h3FFF, 1'b0, 1'b1);
        chk("conv0_valid", 32'(m_tvalid), 1);
        chk("conv0", 32'(m_tdata), 'h2000);
        feed(14'h0000, 1'b0, 1'b1);
        chk("conv1", 32'(m_tdata), 'h0000);
        feed(14'h0000, 1'b0, 1'b1);
        chk("conv2", 32'(m_tdata), 'h1FFF);
        feed(14'h0000, 1'b0, 1'b0);
        chk("conv_end", 32'(m_tvalid), 0);

        // overflow, clear priority, push+pop at full, ordered drain
        m_tready = 1'b0;
        feed(14'h0100, 1'b0, 1'b0);
        feed(14'h0101, 1'b0, 1'b0);
        for (int i = 2; i <= 7; i++) begin
            feed(14'(256 + i), 1'b0, 1'b1);
            if (i == 6) chk("ovf_delay", 32'(overflow), 0);
            if (i == 7) chk("ovf_set", 32'(overflow), 1);
        end
        feed(14'h0000, 1'b0, 1'b1);
        feed(14'h0000, 1'b0, 1'b1);
        clr_stat = 1'b1;
        feed(14'h0000, 1'b0, 1'b0);
        clr_stat = 1'b0;
        chk("ovf_clr_prio", 32'(overflow), 0);
        feed(14'h0155, 1'b0, 1'b0);
        chk("ovf_clr_hold", 32'(overflow), 0);
        chk("hold_valid", 32'(m_tvalid), 1);
        chk("hold_data", 32'(m_tdata), 'h2100);
        feed(14'h0000, 1'b0, 1'b0);
        m_tready = 1'b1;
        feed(14'h0000, 1'b0, 1'b1);
        drain_exp = '{'h2101, 'h2102, 'h2103, 'h2155};
        for (int k = 0; k < 4; k++) begin
            chk("drain_valid", 32'(m_tvalid), 1);
            chk("drain_data", 32'(m_tdata), drain_exp[k]);
            feed(14'h0000, 1'b0, 1'b0);
        end
        chk("drain_empty", 32'(m_tvalid), 0);
        chk("full_pushpop_noovf", 32'(overflow), 0);

        // overrange tagging and counting
        or_pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            feed((i < 5) ? 14'(16 + i) : 14'h0000, (i < 5) ? or_pat[i] : 1'b0, (i >= 2));
            if (i >= 2) begin
                chk("or_tuser", 32'(m_tuser), 32'(or_pat[i-2]));
                chk("or_tdata", 32'(m_tdata), 32'('h2010 + i - 2));
            end
        end
        chk("or_count_2", 32'(or_count), 2);
        feed(14'h0000, 1'b0, 1'b0);
        chk("or_count_3", 32'(or_count), 3);

        // or_count clear priority and saturation
        for (int t = 1; t <= 65550; t++) begin
            clr_stat = (t == 10);
            feed(14'h0000, 1'b1, 1'b1);
            if (t == 10)    chk("or_clr_prio", 32'(or_count), 0);
            if (t == 65544) chk("or_count_fffe", 32'(or_count), 'hFFFE);
            if (t == 65550) chk("or_count_sat", 32'(or_count), 'hFFFF);
        end
        clr_stat = 1'b0;
        feed(14'h0000, 1'b0, 1'b0);
        feed(14'h0000, 1'b0, 1'b0);
        feed(14'h0000, 1'b0, 1'b0);

        // rdy drop with two entries buffered
        m_tready = 1'b0;
        feed(14'h00AA, 1'b0, 1'b0);
        feed(14'h00AB, 1'b0, 1'b0);
        feed(14'h0000, 1'b0, 1'b1);
        feed(14'h0000, 1'b0, 1'b1);
        chk("drop_pre_data", 32'(m_tdata), 'h20AA);
        idelay_rdy = 1'b0;
        feed(14'h0000, 1'b0, 1'b0);
        chk("drop_t1_state", 32'(state), 2);
        feed(14'h0000, 1'b0, 1'b0);
        feed(14'h0000, 1'b0, 1'b0);
        chk("drop_t3_state", 32'(state), 0);
        chk("drop_t3_valid", 32'(m_tvalid), 0);
        chk("drop_stat_kept", 32'(or_count), 'hFFFF);
        idelay_rdy = 1'b1;
        m_tready   = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        chk("rerun_state", 32'(state), 2);
        chk("rerun_no_stale", 32'(m_tvalid), 0);
        feed(14'h1234, 1'b0, 1'b0);
        feed(14'h0000, 1'b0, 1'b0);
        feed(14'h0000, 1'b0, 1'b1);
        chk("rerun_data", 32'(m_tdata), 'h3234);
        feed(14'h0000, 1'b0, 1'b0);
        chk("rerun_empty", 32'(m_tvalid), 0);

`ifdef ADC_CAPTURE_PATTERN_CHK_EN
        idelay_rdy = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        idelay_rdy = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("pat_run", 32'(state), 2);
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
        chk("pat_clr", 32'(pat_err_cnt), 0);
        feed(14'h3FFE, 1'b0, 1'b0);
        feed(14'h3FFF, 1'b0, 1'b0);
        feed(14'h0000, 1'b0, 1'b1);
        feed(14'h0005, 1'b0, 1'b1);
        feed(14'h0000, 1'b0, 1'b1);
        chk("pat_wrap_ok", 32'(pat_err_cnt), 0);
        feed(14'h0000, 1'b0, 1'b1);
        chk("pat_err", 32'(pat_err_cnt), 1);
        feed(14'h0000, 1'b0, 1'b0);
        chk("pat_err_hold", 32'(pat_err_cnt), 1);
`endif

        // reset mid-operation with data buffered
        m_tready = 1'b0;
        feed(14'h0001, 1'b0, 1'b0);
        feed(14'h0000, 1'b0, 1'b0);
        feed(14'h0000, 1'b0, 1'b1);
        feed(14'h0000, 1'b0, 1'b0);
        chk("mid_pre_valid", 32'(m_tvalid), 1);
        rst_adc_n = 1'b0;
        tick();
        chk("mid_rst_state", 32'(state), 0);
        chk("mid_rst_valid", 32'(m_tvalid), 0);
        chk("mid_rst_or_count", 32'(or_count), 0);
        rst_adc_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
